// File: rtl/pid_pkg.sv
// Shared definitions for the steering PID: controller FSM states, the
// Q-format fractional width shared with the motor mixer, and a generic
// signed clamp helper.
package pid_pkg;

  // Fractional bits of all Q-format gains on the steering path.
  localparam int Q_FRAC_W = 8;

  // Working width for clamp arithmetic; wide enough for every internal sum.
  localparam int SAT_W = 48;

  // Controller sequence. The final adder closes the MUL_D cycle, so the
  // output register loads on the edge that leaves MUL_D and the block is
  // back in IDLE while out_valid is high.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_MUL_P = 3'd2,
    ST_MUL_I = 3'd3,
    ST_MUL_D = 3'd4
  } pid_state_e;

  // Clamp a signed value into [lo, hi].
  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] value,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/pid_controller_q_if.sv
// Sample/gain/result bundle between the steering sequencer and the PID.
interface pid_controller_q_if #(
  parameter int DATA_W = 11,
  parameter int GAIN_W = 12
);
  logic [DATA_W-1:0] setpoint;
  logic [DATA_W-1:0] position;
  logic              in_valid;
  logic              in_ready;
  logic [GAIN_W-1:0] kp;
  logic [GAIN_W-1:0] ki;
  logic [GAIN_W-1:0] kd;
  logic              kp_en;
  logic              ki_en;
  logic              kd_en;
  logic              clr_int;
  logic [DATA_W-1:0] pid_output;
  logic              out_valid;
  logic              sat;

  // Sample source side.
  modport master (
    output setpoint, position, in_valid, kp, ki, kd,
    output kp_en, ki_en, kd_en, clr_int,
    input  in_ready, pid_output, out_valid, sat
  );

  // Controller side.
  modport slave (
    input  setpoint, position, in_valid, kp, ki, kd,
    input  kp_en, ki_en, kd_en, clr_int,
    output in_ready, pid_output, out_valid, sat
  );
endinterface

// File: rtl/pid_sat_mul.sv
// Shared gain multiplier: unsigned Q gain times signed operand, floor
// shift by FRAC_W, then saturation to ACC_W signed.
module pid_sat_mul #(
  parameter int GAIN_W = 12,
  parameter int ACC_W  = 20,
  parameter int FRAC_W = 8
) (
  input  logic        [GAIN_W-1:0] gain,
  input  logic signed [ACC_W-1:0]  operand,
  output logic signed [ACC_W-1:0]  result
);
  localparam int PROD_W = GAIN_W + 1 + ACC_W;

  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] shifted;
  logic                     fits;

  // Full-width product, arithmetic shift, saturate when upper bits are not a sign run.
  always_comb begin
    product = PROD_W'($signed({1'b0, gain})) * PROD_W'(operand);
    shifted = product >>> FRAC_W;
    fits    = (&shifted[PROD_W-1:ACC_W-1]) | (~|shifted[PROD_W-1:ACC_W-1]);
    if (fits) begin
      result = shifted[ACC_W-1:0];
    end else if (shifted[PROD_W-1]) begin
      result = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      result = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/pid_controller_q.sv
// Fixed-point steering PID: offset + P + I + D with one time-shared
// multiplier, clamped output, clamped integrator with anti-windup, and
// derivative suppression on the first sample after reset or clear.
module pid_controller_q
  import pid_pkg::*;
#(
  parameter int DATA_W  = 11,
  parameter int GAIN_W  = 12,
  parameter int FRAC_W  = Q_FRAC_W,
  parameter int ACC_W   = 20,
  parameter int OFFSET  = 500,
  parameter int OUT_MIN = 0,
  parameter int OUT_MAX = 1000,
  parameter int I_LIM   = 4000
) (
  input logic         clk,
  input logic         rst,
  pid_controller_q_if.slave bus
);
  localparam int ERR_W = DATA_W + 1;
  localparam int DRV_W = DATA_W + 2;
  localparam int SUM_W = ACC_W + 2;

  pid_state_e               state_q, state_d;
  logic        [DATA_W-1:0] sp_q, sp_d, pos_q, pos_d;
  logic        [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic                     kp_en_q, kp_en_d, ki_en_q, ki_en_d, kd_en_q, kd_en_d;
  logic signed [ERR_W-1:0]  error_q, error_d, error_prev_q, error_prev_d;
  logic signed [DRV_W-1:0]  deriv_q, deriv_d;
  logic                     first_q, first_d;
  logic signed [ACC_W-1:0]  integ_q, integ_d;
  logic signed [ACC_W-1:0]  term_p_q, term_p_d, term_i_q, term_i_d;
  logic                     wind_hi_q, wind_hi_d, wind_lo_q, wind_lo_d;
  logic        [DATA_W-1:0] pid_output_q, pid_output_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  logic        [GAIN_W-1:0] mul_gain;
  logic signed [ACC_W-1:0]  mul_operand;
  logic signed [ACC_W-1:0]  mul_result;

  logic signed [ERR_W-1:0]  err_calc;
  logic signed [DRV_W-1:0]  deriv_calc;
  logic signed [SAT_W-1:0]  integ_sum;
  logic                     windup_hold;
  logic signed [ACC_W-1:0]  term_d_calc;
  logic signed [SUM_W-1:0]  sum_calc;
  logic signed [SAT_W-1:0]  sum_clamped;
  logic                     sum_lo, sum_hi;

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.pid_output = pid_output_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sat        = sat_q;

  // Route the gain/operand pair for the current multiply state.
  always_comb begin
    mul_gain    = '0;
    mul_operand = '0;
    case (state_q)
      ST_MUL_P: begin
        mul_gain    = kp_q;
        mul_operand = ACC_W'(error_q);
      end
      ST_MUL_I: begin
        mul_gain    = ki_q;
        mul_operand = integ_q;
      end
      ST_MUL_D: begin
        mul_gain    = kd_q;
        mul_operand = ACC_W'(deriv_q);
      end
      default: ;
    endcase
  end

  pid_sat_mul #(
    .GAIN_W (GAIN_W),
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .gain    (mul_gain),
    .operand (mul_operand),
    .result  (mul_result)
  );

  // Next-state, datapath updates and output register loads.
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    pos_d        = pos_q;
    kp_d         = kp_q;
    ki_d         = ki_q;
    kd_d         = kd_q;
    kp_en_d      = kp_en_q;
    ki_en_d      = ki_en_q;
    kd_en_d      = kd_en_q;
    error_d      = error_q;
    error_prev_d = error_prev_q;
    deriv_d      = deriv_q;
    first_d      = first_q;
    integ_d      = integ_q;
    term_p_d     = term_p_q;
    term_i_d     = term_i_q;
    wind_hi_d    = wind_hi_q;
    wind_lo_d    = wind_lo_q;
    pid_output_d = pid_output_q;
    out_valid_d  = 1'b0;
    sat_d        = sat_q;

    err_calc    = $signed({1'b0, sp_q}) - $signed({1'b0, pos_q});
    deriv_calc  = first_q ? '0
                : $signed({err_calc[ERR_W-1], err_calc}) -
                  $signed({error_prev_q[ERR_W-1], error_prev_q});
    integ_sum   = SAT_W'(integ_q) + SAT_W'(err_calc);
    // Hold the integrator while the error keeps pushing into the last clamp.
    windup_hold = (wind_hi_q && !err_calc[ERR_W-1] && (err_calc != '0)) ||
                  (wind_lo_q && err_calc[ERR_W-1]);
    term_d_calc = kd_en_q ? mul_result : '0;
    sum_calc    = SUM_W'(OFFSET) + SUM_W'(term_p_q) + SUM_W'(term_i_q) + SUM_W'(term_d_calc);
    sum_clamped = sat_clamp(SAT_W'(sum_calc), SAT_W'(OUT_MIN), SAT_W'(OUT_MAX));
    sum_lo      = sum_calc < SUM_W'(OUT_MIN);
    sum_hi      = sum_calc > SUM_W'(OUT_MAX);

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sp_d    = bus.setpoint;
          pos_d   = bus.position;
          kp_d    = bus.kp;
          ki_d    = bus.ki;
          kd_d    = bus.kd;
          kp_en_d = bus.kp_en;
          ki_en_d = bus.ki_en;
          kd_en_d = bus.kd_en;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        error_d      = err_calc;
        deriv_d      = deriv_calc;
        error_prev_d = err_calc;
        first_d      = 1'b0;
        if (!ki_en_q) begin
          integ_d = '0;
        end else if (!windup_hold) begin
          integ_d = ACC_W'(sat_clamp(integ_sum, SAT_W'(-I_LIM), SAT_W'(I_LIM)));
        end
        state_d = ST_MUL_P;
      end
      ST_MUL_P: begin
        term_p_d = kp_en_q ? mul_result : '0;
        state_d  = ST_MUL_I;
      end
      ST_MUL_I: begin
        term_i_d = ki_en_q ? mul_result : '0;
        state_d  = ST_MUL_D;
      end
      ST_MUL_D: begin
        pid_output_d = DATA_W'(sum_clamped);
        sat_d        = sum_lo | sum_hi;
        wind_hi_d    = sum_hi;
        wind_lo_d    = sum_lo;
        out_valid_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clearing the history wins over any same-cycle update.
    if (bus.clr_int) begin
      integ_d      = '0;
      error_prev_d = '0;
      first_d      = 1'b1;
      wind_hi_d    = 1'b0;
      wind_lo_d    = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      sp_q         <= '0;
      pos_q        <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      kp_en_q      <= 1'b0;
      ki_en_q      <= 1'b0;
      kd_en_q      <= 1'b0;
      error_q      <= '0;
      error_prev_q <= '0;
      deriv_q      <= '0;
      first_q      <= 1'b1;
      integ_q      <= '0;
      term_p_q     <= '0;
      term_i_q     <= '0;
      wind_hi_q    <= 1'b0;
      wind_lo_q    <= 1'b0;
      pid_output_q <= '0;
      out_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      pos_q        <= pos_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
      kd_q         <= kd_d;
      kp_en_q      <= kp_en_d;
      ki_en_q      <= ki_en_d;
      kd_en_q      <= kd_en_d;
      error_q      <= error_d;
      error_prev_q <= error_prev_d;
      deriv_q      <= deriv_d;
      first_q      <= first_d;
      integ_q      <= integ_d;
      term_p_q     <= term_p_d;
      term_i_q     <= term_i_d;
      wind_hi_q    <= wind_hi_d;
      wind_lo_q    <= wind_lo_d;
      pid_output_q <= pid_output_d;
      out_valid_q  <= out_valid_d;
      sat_q        <= sat_d;
    end
  end
endmodule
